rv_control_fsm: RTL and testbench
=================================

# rv_control_fsm

Multi-cycle control unit that sequences the RV32I datapath made of the program counter, instruction memory, register file and ALU. It decodes the current instruction and steps through the datapath phases. It generates the PC-advance, register write-enable, ALU-operation and writeback-select strobes, and runs a req/ack handshake with data memory. It sits beside the datapath in the CPU top and replaces the constant register write-enable the datapath currently uses.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: number of MEM cycles without `dmem_ack` before the controller enters FAULT (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instruction  in  32  current instruction word from instruction memory.
- alu_zero  in  1  ALU result == 0; used for branch resolution.
- halt_req  in  1  request to stall at the next instruction boundary.
- dmem_ack  in  1  data memory completion.
- ir_load  out  1  instruction latch strobe (FETCH).
- pc_en  out  1  one-cycle PC update strobe.
- pc_src  out  1  1 = load branch/jump target; 0 = PC+4.
- reg_wr  out  1  register file write enable.
- alu_op  out  4  ALU operation code.
- alu_src_imm  out  1  1 = ALU operand B is the immediate.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- dmem_req  out  1  data memory request, held until ack.
- dmem_we  out  1  store qualifier, valid while `dmem_req` is high.
- state  out  3  FSM state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, FAULT=5.
- fault  out  1  sticky fault flag.
- cycle_count  out  32  performance counter (see Configuration).
- instret_count  out  32  retired-instruction counter (see Configuration).

## Operation
- FETCH: if `halt_req`=1, stay in FETCH with `ir_load`=0. Otherwise assert `ir_load`, latch opcode, funct3, funct7[5] and rd internally, then go to DECODE.
- DECODE: classify the opcode.
  - Supported: R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111). Go to EXECUTE.
  - Any other opcode, or BRANCH with funct3 not in {000, 001}: go to FAULT.
- EXECUTE: `alu_op` and `alu_src_imm` are valid.
  - R: `alu_op`={funct7[5], funct3}.
  - I: `alu_op`={funct3==101 ? funct7[5] : 0, funct3}, `alu_src_imm`=1.
  - LOAD/STORE: `alu_op`=0000 (ADD), `alu_src_imm`=1, next state MEM.
  - BRANCH: `alu_op`=1000 (SUB). Taken = `alu_zero` for BEQ, !`alu_zero` for BNE. Assert `pc_en`; `pc_src`=taken; next state FETCH.
  - R/I/JAL: next state WRITEBACK.
- MEM: assert `dmem_req`; `dmem_we`=1 for STORE.
  - On `dmem_ack`=1: LOAD goes to WRITEBACK. STORE asserts `pc_en` in that same cycle and goes to FETCH.
  - The MEM wait counter resets on MEM entry. When it reaches TIMEOUT_CYCLES with no ack, go to FAULT.
- WRITEBACK: assert `pc_en` and `reg_wr`, with `reg_wr` forced to 0 when rd==0. Next state FETCH.
  - `wb_sel`: 0 for R/I, 1 for LOAD, 2 for JAL.
  - `pc_src`: 1 for JAL, 0 otherwise.
- FAULT: terminal until reset. `fault`=1; all strobes, `dmem_req` and `reg_wr` are 0.

## Timing
- Reset: `state`=FETCH; every output 0; counters 0; internal instruction fields cleared.
- Latency:
  - R/I/JAL: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4+W cycles; LOAD: 5+W cycles. W = wait cycles before ack; W=0 when ack arrives in the first MEM cycle.
- Output timing: strobes are Moore outputs of the registered state, except `pc_src` in EXECUTE, which follows `alu_zero` combinationally.
- `pc_en` rules:
  - Exactly one `pc_en` pulse per retired instruction.
  - Never two consecutive `pc_en` cycles.
- Handshake: `dmem_req` is never withdrawn before ack except on reset or timeout. `dmem_ack` is ignored outside MEM.
- Reset during MEM: `dmem_req` is 0 on the cycle after `rst_n` is sampled low; no `reg_wr` or `pc_en` is issued.
- `halt_req` is honoured only in FETCH; an instruction already in flight completes.

## Configuration
- RV_CTRL_PERF_CNT_EN defined:
  - `cycle_count` increments every non-FAULT cycle after reset.
  - `instret_count` increments on every `pc_en`.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: both ports are driven constant 0 and no counter flops are synthesized. The port list is unchanged.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3): `state` 0→1→2→4→0. `reg_wr`=1 only in the WRITEBACK cycle; `alu_op`=0000; one `pc_en`.
- SUB (0x402081B3): `alu_op`=1000. ADDI x0,x0,0 (0x00000013): `reg_wr` stays 0 in WRITEBACK.
- BEQ with `alu_zero`=1: `pc_en`=1 and `pc_src`=1 in EXECUTE; 3-cycle instruction. With `alu_zero`=0: `pc_src`=0.
- LW with ack delayed 3 cycles: `dmem_req` high for 4 MEM cycles with `dmem_we`=0, then WRITEBACK with `wb_sel`=1. SW with ack in the first MEM cycle: `pc_en` in that cycle.
- LW with no ack and TIMEOUT_CYCLES=4: FAULT after 4 MEM cycles, `fault`=1 sticky. Opcode 0x7F likewise faults from DECODE. Applying `rst_n`=0 returns to FETCH with `fault`=0.
- With RV_CTRL_PERF_CNT_EN: 10 ADDs give `instret_count`=10 and `cycle_count`=40. `halt_req` asserted at FETCH holds state 0 and freezes `instret_count`.

Source files
------------

// File: rtl/rv_control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing with a data-memory req/ack handshake.
// Optional performance counters are enabled by defining RV_CTRL_PERF_CNT_EN.
module rv_control_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        alu_zero,
    input  logic        halt_req,
    input  logic        dmem_ack,
    output logic        ir_load,
    output logic        pc_en,
    output logic        pc_src,
    output logic        reg_wr,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic [1:0]  wb_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     st;
    logic [6:0] ir_opcode;
    logic [2:0] ir_funct3;
    logic       ir_f7b5;
    logic [4:0] ir_rd;
    logic [7:0] wait_cnt;
    logic       pc_en_q;
    logic       pc_src_q;

    // rs1/rs2/immediate fields belong to the datapath, not the controller
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction[31], instruction[29:15]};

    logic is_r, is_i, is_load, is_store, is_branch, is_jal, supported;
    logic branch_taken, store_done;

    assign is_r      = (ir_opcode == OP_R);
    assign is_i      = (ir_opcode == OP_I);
    assign is_load   = (ir_opcode == OP_LOAD);
    assign is_store  = (ir_opcode == OP_STORE);
    assign is_branch = (ir_opcode == OP_BRANCH);
    assign is_jal    = (ir_opcode == OP_JAL);
    assign supported = is_r | is_i | is_load | is_store | is_jal
                     | (is_branch & (ir_funct3[2:1] == 2'b00));

    assign branch_taken = (ir_funct3[0] == 1'b0) ? alu_zero : ~alu_zero;
    // A store retires in the ack cycle itself; a reset in that cycle cancels the PC update
    assign store_done   = rst_n & (st == MEM) & is_store & dmem_ack;

    assign ir_load = rst_n & (st == FETCH) & ~halt_req;
    assign pc_en   = pc_en_q | store_done;
    assign pc_src  = (st == EXECUTE && is_branch) ? branch_taken : pc_src_q;
    assign state   = st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= FETCH;
            ir_opcode   <= '0;
            ir_funct3   <= '0;
            ir_f7b5     <= 1'b0;
            ir_rd       <= '0;
            wait_cnt    <= '0;
            pc_en_q     <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_wr      <= 1'b0;
            alu_op      <= '0;
            alu_src_imm <= 1'b0;
            wb_sel      <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later non-blocking writes in the same
            // cycle, so every one-cycle strobe drops automatically unless the next state re-asserts it.
            pc_en_q     <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_wr      <= 1'b0;
            alu_op      <= '0;
            alu_src_imm <= 1'b0;
            wb_sel      <= '0;

            case (st)
                FETCH: begin
                    if (!halt_req) begin
                        ir_opcode <= instruction[6:0];
                        ir_funct3 <= instruction[14:12];
                        ir_f7b5   <= instruction[30];
                        ir_rd     <= instruction[11:7];
                        st        <= DECODE;
                    end
                end

                DECODE: begin
                    if (supported) begin
                        st      <= EXECUTE;
                        pc_en_q <= is_branch;
                        if (is_r) begin
                            alu_op <= {ir_f7b5, ir_funct3};
                        end else if (is_i) begin
                            alu_op      <= {(ir_funct3 == 3'b101) & ir_f7b5, ir_funct3};
                            alu_src_imm <= 1'b1;
                        end else if (is_load || is_store) begin
                            alu_src_imm <= 1'b1;
                        end else if (is_branch) begin
                            alu_op <= 4'b1000;
                        end
                    end else begin
                        st    <= FAULT;
                        fault <= 1'b1;
                    end
                end

                EXECUTE: begin
                    if (is_branch) begin
                        st <= FETCH;
                    end else if (is_load || is_store) begin
                        st       <= MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= is_store;
                        wait_cnt <= '0;
                    end else begin
                        st       <= WRITEBACK;
                        pc_en_q  <= 1'b1;
                        reg_wr   <= (ir_rd != 5'd0);
                        wb_sel   <= is_jal ? 2'd2 : 2'd0;
                        pc_src_q <= is_jal;
                    end
                end

                MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (is_store) begin
                            st <= FETCH;
                        end else begin
                            st      <= WRITEBACK;
                            pc_en_q <= 1'b1;
                            reg_wr  <= (ir_rd != 5'd0);
                            wb_sel  <= 2'd1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        st       <= FAULT;
                        fault    <= 1'b1;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                WRITEBACK: st <= FETCH;

                FAULT: st <= FAULT;

                default: begin
                    st    <= FAULT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

`ifdef RV_CTRL_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (st != FAULT) cycle_q <= cycle_q + 32'd1;
            if (pc_en) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_rv_control_fsm.sv
// Directed bench for rv_control_fsm: a reference model queues per-cycle stimulus and expected outputs,
// which are popped and compared at the falling clock edge.
module tb_rv_control_fsm;

    localparam int TIMEOUT = 4;
`ifdef RV_CTRL_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_SRAI = 32'h4030D293;
    localparam logic [31:0] I_ORI  = 32'h4000E293;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BLT  = 32'h0020C463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_LW   = 32'h0040A183;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    typedef struct packed {
        logic [31:0] instr;
        logic        zero;
        logic        halt;
        logic        ack;
        logic        rst_n;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_load;
        logic       pc_en;
        logic       pc_src;
        logic       reg_wr;
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic [1:0] wb_sel;
        logic       dmem_req;
        logic       dmem_we;
        logic       fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        alu_zero, halt_req, dmem_ack;
    logic        ir_load, pc_en, pc_src, reg_wr, alu_src_imm, dmem_req, dmem_we, fault;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic [31:0] cycle_count, instret_count;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    n_cycle = 0;
    int    cyc_m = 0;
    int    ins_m = 0;

    rv_control_fsm #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .alu_zero(alu_zero),
        .halt_req(halt_req), .dmem_ack(dmem_ack), .ir_load(ir_load), .pc_en(pc_en),
        .pc_src(pc_src), .reg_wr(reg_wr), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .wb_sel(wb_sel), .dmem_req(dmem_req), .dmem_we(dmem_we), .state(state),
        .fault(fault), .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic push(input stim_t s, input exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    function automatic stim_t mk_stim(input logic [31:0] ins, input logic zero, input logic halt,
                                      input logic ack, input logic rst);
        stim_t s;
        s.instr = ins; s.zero = zero; s.halt = halt; s.ack = ack; s.rst_n = rst;
        return s;
    endfunction

    task automatic push_fault(input int n);
        exp_t e;
        e = '0; e.st = 3'd5; e.fault = 1'b1;
        for (int i = 0; i < n; i++) push(mk_stim(I_ADD, 1'b0, 1'b0, 1'b1, 1'b1), e);
    endtask

    task automatic push_halt(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) push(mk_stim(I_ADD, 1'b0, 1'b1, 1'b0, 1'b1), e);
    endtask

    // First cycle still shows the pre-reset state; the second shows the cleared state.
    task automatic push_reset(input exp_t prev);
        exp_t e;
        e = '0;
        push(mk_stim(I_ADD, 1'b0, 1'b0, 1'b1, 1'b0), prev);
        push(mk_stim(I_ADD, 1'b0, 1'b0, 1'b1, 1'b0), e);
    endtask

    // wait_cyc < 0 means memory never acknowledges.
    task automatic push_instr(input logic [31:0] ins, input logic zero, input int wait_cyc,
                              input logic stray);
        stim_t s;
        exp_t  e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       ok, ld, sto;
        opc = ins[6:0];
        f3  = ins[14:12];
        ld  = (opc == OP_LOAD);
        sto = (opc == OP_STORE);
        ok  = (opc == OP_R) || (opc == OP_I) || ld || sto || (opc == OP_JAL)
           || ((opc == OP_BRANCH) && (f3 == 3'b000 || f3 == 3'b001));

        s = mk_stim(ins, zero, 1'b0, stray, 1'b1);
        e = '0; e.ir_load = 1'b1;
        push(s, e);
        s.instr = ~ins;
        e = '0; e.st = 3'd1;
        push(s, e);
        if (!ok) begin
            push_fault(3);
            return;
        end

        e = '0; e.st = 3'd2;
        if (opc == OP_R) e.alu_op = {ins[30], f3};
        if (opc == OP_I) begin
            e.alu_op = {(f3 == 3'b101) ? ins[30] : 1'b0, f3};
            e.alu_src_imm = 1'b1;
        end
        if (ld || sto) e.alu_src_imm = 1'b1;
        if (opc == OP_BRANCH) begin
            e.alu_op = 4'b1000;
            e.pc_en  = 1'b1;
            e.pc_src = (f3 == 3'b000) ? zero : ~zero;
        end
        push(s, e);
        if (opc == OP_BRANCH) return;

        if (ld || sto) begin
            e = '0; e.st = 3'd3; e.dmem_req = 1'b1; e.dmem_we = sto;
            if (wait_cyc < 0) begin
                s.ack = 1'b0;
                for (int i = 0; i < TIMEOUT; i++) push(s, e);
                push_fault(3);
                return;
            end
            for (int i = 0; i <= wait_cyc; i++) begin
                s.ack = (i == wait_cyc);
                e.pc_en = sto && s.ack;
                push(s, e);
            end
            if (sto) return;
            s.ack = stray;
        end

        e = '0; e.st = 3'd4; e.pc_en = 1'b1;
        e.reg_wr = (ins[11:7] != 5'd0);
        e.wb_sel = ld ? 2'd1 : ((opc == OP_JAL) ? 2'd2 : 2'd0);
        e.pc_src = (opc == OP_JAL);
        push(s, e);
    endtask

    task automatic run_queue();
        stim_t s;
        exp_t  e, obs;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            instruction = s.instr;
            alu_zero    = s.zero;
            halt_req    = s.halt;
            dmem_ack    = s.ack;
            rst_n       = s.rst_n;
            #1;
            obs.st = state; obs.ir_load = ir_load; obs.pc_en = pc_en; obs.pc_src = pc_src;
            obs.reg_wr = reg_wr; obs.alu_op = alu_op; obs.alu_src_imm = alu_src_imm;
            obs.wb_sel = wb_sel; obs.dmem_req = dmem_req; obs.dmem_we = dmem_we; obs.fault = fault;
            check($sformatf("outputs@cycle%0d", n_cycle), 32'(obs), 32'(e));
            check($sformatf("cycle_count@cycle%0d", n_cycle), cycle_count, PERF_EN ? 32'(cyc_m) : 32'd0);
            check($sformatf("instret_count@cycle%0d", n_cycle), instret_count, PERF_EN ? 32'(ins_m) : 32'd0);
            if (!s.rst_n) begin
                cyc_m = 0;
                ins_m = 0;
            end else begin
                if (e.st != 3'd5) cyc_m++;
                if (e.pc_en) ins_m++;
            end
            n_cycle++;
        end
    endtask

    initial begin
        exp_t e, fault_rec;
        fault_rec = '0; fault_rec.st = 3'd5; fault_rec.fault = 1'b1;

        rst_n = 1'b0; instruction = '0; alu_zero = 1'b0; halt_req = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        e = '0;
        push(mk_stim(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0), e);
        run_queue();

        // ALU and jump instructions
        push_instr(I_ADD, 1'b0, 0, 1'b0);
        push_instr(I_SUB, 1'b1, 0, 1'b0);
        push_instr(I_NOP, 1'b0, 0, 1'b0);
        push_instr(I_SRAI, 1'b0, 0, 1'b0);
        push_instr(I_ORI, 1'b0, 0, 1'b0);
        push_instr(I_JAL, 1'b0, 0, 1'b0);
        run_queue();

        // Branches in both directions
        push_instr(I_BEQ, 1'b1, 0, 1'b0);
        push_instr(I_BEQ, 1'b0, 0, 1'b0);
        push_instr(I_BNE, 1'b0, 0, 1'b0);
        push_instr(I_BNE, 1'b1, 0, 1'b0);
        run_queue();

        // Halt at the boundary, then memory ops; stray acks outside MEM must be ignored
        push_halt(3);
        push_instr(I_SW, 1'b0, 0, 1'b1);
        push_instr(I_LW, 1'b0, 3, 1'b0);
        push_instr(I_LW, 1'b0, 0, 1'b1);
        run_queue();

        // Reset while a store waits in MEM: no pc_en even with ack present
        push_instr(I_NOP, 1'b0, 0, 1'b0);
        e = '0; e.ir_load = 1'b1;
        push(mk_stim(I_SW, 1'b0, 1'b0, 1'b0, 1'b1), e);
        e = '0; e.st = 3'd1;
        push(mk_stim(I_SW, 1'b0, 1'b0, 1'b0, 1'b1), e);
        e = '0; e.st = 3'd2; e.alu_src_imm = 1'b1;
        push(mk_stim(I_SW, 1'b0, 1'b0, 1'b0, 1'b1), e);
        e = '0; e.st = 3'd3; e.dmem_req = 1'b1; e.dmem_we = 1'b1;
        push(mk_stim(I_SW, 1'b0, 1'b0, 1'b0, 1'b1), e);
        push(mk_stim(I_SW, 1'b0, 1'b0, 1'b1, 1'b0), e);
        e = '0;
        push(mk_stim(I_SW, 1'b0, 1'b0, 1'b1, 1'b0), e);
        run_queue();

        // Faults: memory timeout, illegal opcode, unsupported branch; each cleared by reset
        push_instr(I_LW, 1'b0, -1, 1'b0);
        push_reset(fault_rec);
        push_instr(I_BAD, 1'b0, 0, 1'b0);
        push_reset(fault_rec);
        push_instr(I_BLT, 1'b0, 0, 1'b0);
        push_reset(fault_rec);
        run_queue();

        // Ten ADDs from reset, then halt to freeze retirement
        for (int i = 0; i < 10; i++) push_instr(I_ADD, 1'b0, 0, 1'b0);
        push_halt(1);
        run_queue();
        check("cycle_count_after_10_add", cycle_count, PERF_EN ? 32'd40 : 32'd0);
        check("instret_after_10_add", instret_count, PERF_EN ? 32'd10 : 32'd0);
        push_halt(3);
        run_queue();
        check("instret_frozen_in_halt", instret_count, PERF_EN ? 32'd10 : 32'd0);
        check("state_held_in_halt", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
